// File: rtl/comp_run_ctrl.sv
// -----------------------------------------------------------------------------
// comp_run_ctrl
//
// Boot/run sequencer for the `comp` core. It streams a program image from a
// host into core memory through the core's out-of-band write port, holds the
// core in reset while loading and for a few cycles afterwards, then lets the
// core run until it raises halt. Every word the core emits on out/outen while
// running is captured into a small FIFO that the host drains at its own pace.
//
// Optional feature (compile-time macro COMP_CTRL_TIMEOUT_EN):
//   defined   : a run that has not halted after MAX_CYCLES cycles is ended and
//               timed_out is raised.
//   undefined : a run ends only on halt; timed_out is tied low and MAX_CYCLES
//               has no effect.
//
// Parameters
//   IMG_WORDS   words written per load (addresses 0..IMG_WORDS-1)
//   OUT_DEPTH   capture FIFO depth in words (power of 2)
//   RST_CYCLES  cycles core_rst stays high after the load completes (>= 1)
//   MAX_CYCLES  run-cycle limit (timeout build only)
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               pulse, starts a load from IDLE or DONE
//   img_valid/img_data  host image stream; img_ready is high only in LOAD
//   oob_wen/oob_wr_addr/oob_wr_data  registered writes into core memory
//   core_rst            registered reset to the core
//   halt, outen, out    core status and output stream (used only in RUN)
//   rd_en/rd_data/rd_empty/out_count  host side of the capture FIFO
//   overflow            sticky: a captured word was dropped (FIFO full)
//   busy, done          LOAD/CORE_RST/RUN and DONE state indications
//   timed_out           the last run was ended by the cycle limit
//   run_cycles          cycles spent in RUN for the current or last run
// -----------------------------------------------------------------------------
module comp_run_ctrl #(
  parameter int unsigned IMG_WORDS  = 256,
  parameter int unsigned OUT_DEPTH  = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  // host image stream
  input  logic                         img_valid,
  input  logic [31:0]                  img_data,
  output logic                         img_ready,
  // core out-of-band write port and reset
  output logic                         oob_wen,
  output logic [31:0]                  oob_wr_addr,
  output logic [31:0]                  oob_wr_data,
  output logic                         core_rst,
  // core status / output stream
  input  logic                         halt,
  input  logic                         outen,
  input  logic [31:0]                  out,
  // host side of the capture FIFO
  input  logic                         rd_en,
  output logic [31:0]                  rd_data,
  output logic                         rd_empty,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         overflow,
  // status
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [31:0]                  run_cycles
);

  // ---------------------------------------------------------------------------
  // Local sizes
  // ---------------------------------------------------------------------------
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [31:0]       LAST_IDX  = 32'(IMG_WORDS - 1);
  localparam logic [RCW-1:0]    RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(OUT_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CORE_RST,
    S_RUN,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [31:0]        word_idx;     // next image address to be written
  logic [RCW-1:0]     rst_cnt;      // cycles already spent in CORE_RST

  logic               start_ok;     // start accepted this cycle
  logic               in_run;
  logic               cycle_limit;  // run has reached its cycle budget

  logic [31:0]        fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               cap_req;      // core presents a word this cycle
  logic               do_push;
  logic               do_pop;

  // ---------------------------------------------------------------------------
  // Decoded state and handshake terms
  // ---------------------------------------------------------------------------
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign in_run    = (state == S_RUN);
  assign img_ready = (state == S_LOAD);
  assign busy      = (state == S_LOAD) || (state == S_CORE_RST) || in_run;
  assign done      = (state == S_DONE);

`ifdef COMP_CTRL_TIMEOUT_EN
  assign cycle_limit = (run_cycles == 32'(MAX_CYCLES - 1));
`else
  assign cycle_limit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  //
  // oob_wen defaults low every cycle so a write strobe lasts exactly one cycle
  // per accepted image word. The address/data registers simply hold their last
  // value while the strobe is low.
  // ---------------------------------------------------------------------------
  // NOTE: state lives in always_ff with non-blocking (<=) assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word_idx    <= '0;
      rst_cnt     <= '0;
      oob_wen     <= 1'b0;
      oob_wr_addr <= '0;
      oob_wr_data <= '0;
      core_rst    <= 1'b1;
      run_cycles  <= '0;
    end else begin
      oob_wen <= 1'b0;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            word_idx   <= '0;
            run_cycles <= '0;
            core_rst   <= 1'b1;
          end
        end

        S_LOAD: begin
          if (img_valid) begin
            oob_wen     <= 1'b1;
            oob_wr_addr <= word_idx;
            oob_wr_data <= img_data;
            word_idx    <= word_idx + 32'd1;
            // The final write still lands on the cycle after this handshake,
            // overlapping the first CORE_RST cycle.
            if (word_idx == LAST_IDX) begin
              state   <= S_CORE_RST;
              rst_cnt <= '0;
            end
          end
        end

        S_CORE_RST: begin
          // core_rst is dropped on the transition so it is already low in the
          // first RUN cycle.
          if (rst_cnt == RST_LAST) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (halt || cycle_limit) begin
            state    <= S_DONE;
            core_rst <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout flag. halt has priority in the limit cycle, so a core that halts
  // exactly at the budget is not reported as timed out.
  // ---------------------------------------------------------------------------
`ifdef COMP_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      timed_out <= 1'b0;
    end else if (in_run && !halt && cycle_limit) begin
      timed_out <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Capture FIFO
  //
  // A word offered while the FIFO is full is dropped even if the host pops in
  // the same cycle; fullness is judged on the pre-edge occupancy.
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full = (count == FIFO_FULL);
  assign cap_req   = in_run && outen;
  assign do_push   = cap_req && !fifo_full;
  assign do_pop    = rd_en && (count != '0);

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cap_req && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_ptr/count, which are reset, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= out;
    end
  end

  assign rd_data   = fifo_mem[rd_ptr];
  assign rd_empty  = (count == '0);
  assign out_count = count;

endmodule

// File: doc/comp_run_ctrl.md
Name: comp_run_ctrl

Overview:
Synthesizable boot/run sequencer for the `comp` core.
- Streams a program image from a host into core memory through the core's out-of-band write port.
- Holds the core in reset during load, releases it, then runs until the core signals halt.
- Captures every `out`/`outen` word into an internal FIFO that the host drains; replaces the behavioural load/run/capture loop of the simulation driver.

Parameters:
IMG_WORDS, 256, number of 32-bit words written per load (addresses 0..IMG_WORDS-1)
OUT_DEPTH, 32, output capture FIFO depth in words (power of 2)
RST_CYCLES, 2, cycles core_rst is held high after load completes (>=1)
MAX_CYCLES, 100000, run-cycle limit (used only with COMP_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins load from IDLE or DONE; ignored in other states
img_valid  in  1  host image word valid
img_data  in  32  host image word
img_ready  out  1  high only in LOAD
oob_wen  out  1  to core oob_wen
oob_wr_addr  out  32  to core oob_wr_addr
oob_wr_data  out  32  to core oob_wr_data
core_rst  out  1  to core rst
halt  in  1  from core
outen  in  1  from core
out  in  32  from core
rd_en  in  1  pop capture FIFO
rd_data  out  32  FIFO head word (combinational); undefined when empty
rd_empty  out  1  FIFO empty
out_count  out  6  words currently held (width clog2(OUT_DEPTH)+1)
overflow  out  1  sticky: a captured word was dropped because the FIFO was full
busy  out  1  state is LOAD, CORE_RST or RUN
done  out  1  state is DONE
timed_out  out  1  run ended by cycle limit
run_cycles  out  32  cycles spent in RUN for the current or last run

Behaviour:
Reset values:
- State IDLE.
- oob_wen=0, oob_wr_addr=0, oob_wr_data=0, core_rst=1.
- FIFO empty, out_count=0, overflow=0, busy=0, done=0, timed_out=0, run_cycles=0.

States: IDLE -> LOAD -> CORE_RST -> RUN -> DONE; DONE -> LOAD on start.
- IDLE/DONE + start:
  - go LOAD; word index=0; FIFO pointers cleared; overflow, timed_out and run_cycles cleared; done drops the next cycle.
- LOAD:
  - core_rst=1, img_ready=1.
  - Each img_valid&&img_ready handshake registers oob_wen=1, oob_wr_addr=index, oob_wr_data=img_data on the next cycle, then index++.
  - Cycles without a handshake register oob_wen=0.
  - Handshake on index IMG_WORDS-1 moves to CORE_RST; its write still appears the following cycle.
- CORE_RST:
  - oob_wen=0, core_rst=1 for exactly RST_CYCLES cycles, then RUN.
  - core_rst=0 is registered, so it is low on the first RUN cycle.
- RUN:
  - run_cycles++ every cycle; core_rst=0.
  - Capture: outen=1 with FIFO not full writes `out`; outen=1 with FIFO full drops the word and sets overflow.
  - Capture and rd_en in the same cycle both take effect.
  - halt=1 sampled: go DONE. An outen in that same cycle is still captured.
- DONE:
  - core_rst=1 from the next cycle; done=1.
  - FIFO contents retained until the next start.
- FIFO reads:
  - Allowed in any state; rd_en on empty is ignored.
  - Pointers wrap modulo OUT_DEPTH.
- outen and halt are ignored outside RUN.
- rst mid-operation: immediate return to reset values; any partial load is abandoned; no further oob writes.

Optional Feature:
COMP_CTRL_TIMEOUT_EN
- Defined:
  - In RUN, when run_cycles reaches MAX_CYCLES-1 and halt=0: go DONE with timed_out=1.
  - halt in the same cycle wins, so timed_out stays 0.
- Undefined:
  - RUN ends only on halt; timed_out tied 0; MAX_CYCLES unused.

Test Plan:
1. IMG_WORDS=4; stream A0..A3 with img_valid held high -> oob_wen high 4 consecutive cycles, addr 0,1,2,3 with data A0..A3; core_rst low exactly RST_CYCLES cycles after the last write.
2. img_valid toggled 1,0,1,0... -> oob_wen pulses only after handshakes; addresses still 0..3 contiguous with no duplicates.
3. RUN: outen with out=5,7,9, then halt on cycle 10 -> done=1, out_count=3; three rd_en pops return 5,7,9; rd_empty=1 afterwards.
4. OUT_DEPTH=4 with 6 outen pulses before halt -> out_count=4, overflow=1, pops return the first 4 words.
5. COMP_CTRL_TIMEOUT_EN, MAX_CYCLES=20, halt never asserted -> DONE after 20 RUN cycles, timed_out=1, run_cycles=20. Repeat with halt in that final cycle -> timed_out=0.
6. Assert rst during LOAD after 2 words -> all outputs at reset values next cycle; a later start reloads from address 0.
